// File: rtl/fb_pkg.sv
// Shared types and frame geometry for the frame memory arbiter.
// Pixels are 12-bit {r,g,b} with 4 bits per channel.
package fb_pkg;

  localparam int H_PIXELS_DEF = 640;
  localparam int V_PIXELS_DEF = 480;
  localparam int ADDR_W       = $clog2(H_PIXELS_DEF * V_PIXELS_DEF);
  localparam int X_W          = 10;
  localparam int Y_W          = 9;
  localparam int PIX_W        = 12;

  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } pixel_t;

  typedef logic [PIX_W-1:0] pixel_raw_t;

  typedef enum logic {
    CLR_IDLE = 1'b0,
    CLR_RUN  = 1'b1
  } clr_state_e;

endpackage

// File: rtl/frame_mem_arbiter_if.sv
// Bundle of scanout, writer, clear and memory-port signals around the arbiter.
// slave is the arbiter's view; master is the surrounding system's view.
interface frame_mem_arbiter_if;
  import fb_pkg::*;

  logic              rd_req;
  logic [X_W-1:0]    rd_x;
  logic [Y_W-1:0]    rd_y;
  logic              rd_valid;
  pixel_raw_t        rd_pixel;

  logic              wr0_valid;
  logic [X_W-1:0]    wr0_x;
  logic [Y_W-1:0]    wr0_y;
  pixel_raw_t        wr0_pixel;
  logic              wr0_ready;

  logic              wr1_valid;
  logic [X_W-1:0]    wr1_x;
  logic [Y_W-1:0]    wr1_y;
  pixel_raw_t        wr1_pixel;
  logic              wr1_ready;

  logic              clr_start;
  pixel_raw_t        clr_color;
  logic              clr_busy;
  logic              clr_done;

  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  pixel_raw_t        mem_wdata;
  pixel_raw_t        mem_rdata;

  logic              wr_err;

  modport slave (
    input  rd_req, rd_x, rd_y,
    output rd_valid, rd_pixel,
    input  wr0_valid, wr0_x, wr0_y, wr0_pixel,
    output wr0_ready,
    input  wr1_valid, wr1_x, wr1_y, wr1_pixel,
    output wr1_ready,
    input  clr_start, clr_color,
    output clr_busy, clr_done,
    output mem_en, mem_we, mem_addr, mem_wdata,
    input  mem_rdata,
    output wr_err
  );

  modport master (
    output rd_req, rd_x, rd_y,
    input  rd_valid, rd_pixel,
    output wr0_valid, wr0_x, wr0_y, wr0_pixel,
    input  wr0_ready,
    output wr1_valid, wr1_x, wr1_y, wr1_pixel,
    input  wr1_ready,
    output clr_start, clr_color,
    input  clr_busy, clr_done,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    output mem_rdata,
    input  wr_err
  );

endinterface

// File: rtl/fb_rr_arb2.sv
// Two-requester round-robin arbiter; a grant is only given while en_i is high.
// On a tie the requester not granted last wins; last_q resets to requester 1.
module fb_rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en_i,
  input  logic [1:0] req_i,
  output logic [1:0] gnt_o
);

  logic last_q;
  logic last_d;

  always_comb begin
    gnt_o = 2'b00;
    if (en_i) begin
      if (req_i == 2'b11) begin
        gnt_o = last_q ? 2'b01 : 2'b10;
      end else begin
        gnt_o = req_i;
      end
    end
  end

  // A grant always coincides with a transfer, so the pointer follows the grant.
  always_comb begin
    last_d = last_q;
    if (gnt_o[0]) begin
      last_d = 1'b0;
    end else if (gnt_o[1]) begin
      last_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q <= 1'b1;
    end else begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/frame_mem_arbiter.sv
// Single-port frame memory arbiter: scanout read > clear sequencer > round-robin writers.
// Define FB_ARB_BOUNDS_CHECK_EN to drop out-of-frame writes and raise a sticky wr_err.
module frame_mem_arbiter
  import fb_pkg::*;
#(
  parameter int H_PIXELS = H_PIXELS_DEF,
  parameter int V_PIXELS = V_PIXELS_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  frame_mem_arbiter_if.slave bus
);

  localparam int                NUM_PIX   = H_PIXELS * V_PIXELS;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_PIX - 1);

  function automatic logic [ADDR_W-1:0] pix_addr(input logic [X_W-1:0] x,
                                                 input logic [Y_W-1:0] y);
    return ADDR_W'(y) * ADDR_W'(H_PIXELS) + ADDR_W'(x);
  endfunction

  clr_state_e        state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  pixel_t            color_q, color_d;
  logic              done_q, done_d;
  logic              clr_busy;

  logic              rd_pend_q;
  logic              rd_valid_q;
  pixel_raw_t        rd_pixel_q;

  logic [1:0]        wr_req;
  logic [1:0]        wr_gnt;
  logic              arb_en;
  logic              wr0_ok;
  logic              wr1_ok;

  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  pixel_raw_t        mem_wdata;

  assign clr_busy = (state_q == CLR_RUN);
  assign arb_en   = !bus.rd_req && !clr_busy;
  assign wr_req   = {bus.wr1_valid, bus.wr0_valid};

  fb_rr_arb2 u_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .en_i  (arb_en),
    .req_i (wr_req),
    .gnt_o (wr_gnt)
  );

  assign bus.wr0_ready = wr_gnt[0];
  assign bus.wr1_ready = wr_gnt[1];

`ifdef FB_ARB_BOUNDS_CHECK_EN
  function automatic logic in_frame(input logic [X_W-1:0] x, input logic [Y_W-1:0] y);
    return (int'(x) < H_PIXELS) && (int'(y) < V_PIXELS);
  endfunction

  logic wr_err_q, wr_err_d;

  assign wr0_ok = in_frame(bus.wr0_x, bus.wr0_y);
  assign wr1_ok = in_frame(bus.wr1_x, bus.wr1_y);

  // Out-of-frame writes still complete their handshake; only the memory write is dropped.
  always_comb begin
    wr_err_d = wr_err_q;
    if ((wr_gnt[0] && !wr0_ok) || (wr_gnt[1] && !wr1_ok)) begin
      wr_err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_err_q <= 1'b0;
    end else begin
      wr_err_q <= wr_err_d;
    end
  end

  assign bus.wr_err = wr_err_q;
`else
  assign wr0_ok     = 1'b1;
  assign wr1_ok     = 1'b1;
  assign bus.wr_err = 1'b0;
`endif

  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (bus.rd_req) begin
      mem_en   = 1'b1;
      mem_addr = pix_addr(bus.rd_x, bus.rd_y);
    end else if (clr_busy) begin
      mem_en    = 1'b1;
      mem_we    = 1'b1;
      mem_addr  = cnt_q;
      mem_wdata = color_q;
    end else if (wr_gnt[0]) begin
      mem_en    = wr0_ok;
      mem_we    = wr0_ok;
      mem_addr  = wr0_ok ? pix_addr(bus.wr0_x, bus.wr0_y) : '0;
      mem_wdata = wr0_ok ? bus.wr0_pixel : '0;
    end else if (wr_gnt[1]) begin
      mem_en    = wr1_ok;
      mem_we    = wr1_ok;
      mem_addr  = wr1_ok ? pix_addr(bus.wr1_x, bus.wr1_y) : '0;
      mem_wdata = wr1_ok ? bus.wr1_pixel : '0;
    end
  end

  assign bus.mem_en    = mem_en;
  assign bus.mem_we    = mem_we;
  assign bus.mem_addr  = mem_addr;
  assign bus.mem_wdata = mem_wdata;

  // Clear sequencer: the counter only advances on cycles the scanout leaves free.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    color_d = color_q;
    done_d  = 1'b0;
    unique case (state_q)
      CLR_IDLE: begin
        if (bus.clr_start) begin
          state_d = CLR_RUN;
          cnt_d   = '0;
          color_d = bus.clr_color;
        end
      end
      CLR_RUN: begin
        if (!bus.rd_req) begin
          if (cnt_q == LAST_ADDR) begin
            state_d = CLR_IDLE;
            done_d  = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: state_d = CLR_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= CLR_IDLE;
      cnt_q   <= '0;
      color_q <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      color_q <= color_d;
      done_q  <= done_d;
    end
  end

  assign bus.clr_busy = clr_busy;
  assign bus.clr_done = done_q;

  // Read data arrives the cycle after issue and is registered once more for output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_pend_q  <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_pixel_q <= '0;
    end else begin
      rd_pend_q  <= bus.rd_req;
      rd_valid_q <= rd_pend_q;
      if (rd_pend_q) begin
        rd_pixel_q <= bus.mem_rdata;
      end
    end
  end

  assign bus.rd_valid = rd_valid_q;
  assign bus.rd_pixel = rd_pixel_q;

endmodule

// File: tb/tb_frame_mem_arbiter.sv
// Self-checking bench for frame_mem_arbiter with a behavioural memory and arbitration model.
// Uses a 640x8 frame so full clears stay short; honours FB_ARB_BOUNDS_CHECK_EN.
module tb_frame_mem_arbiter;
  import fb_pkg::*;

  localparam int H    = 640;
  localparam int V    = 8;
  localparam int NPIX = H * V;
`ifdef FB_ARB_BOUNDS_CHECK_EN
  localparam bit BOUNDS = 1'b1;
`else
  localparam bit BOUNDS = 1'b0;
`endif

  typedef struct packed {
    logic        v;
    logic [11:0] p;
  } rd_exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  frame_mem_arbiter_if bus ();

  frame_mem_arbiter #(.H_PIXELS(H), .V_PIXELS(V)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  logic [11:0] mem [0:NPIX-1];
  logic [11:0] rdata_q = 12'h000;
  assign bus.mem_rdata = rdata_q;

  always @(posedge clk) begin
    if (bus.mem_en && !bus.mem_we)
      rdata_q <= (int'(bus.mem_addr) < NPIX) ? mem[bus.mem_addr] : 12'h000;
    if (bus.mem_en && bus.mem_we && int'(bus.mem_addr) < NPIX)
      mem[bus.mem_addr] = bus.mem_wdata;
  end

  int n_checks = 0;
  int n_pass   = 0;
  int mdl_last = 1;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle;
    bus.rd_req = 1'b0; bus.rd_x = '0; bus.rd_y = '0;
    bus.wr0_valid = 1'b0; bus.wr0_x = '0; bus.wr0_y = '0; bus.wr0_pixel = '0;
    bus.wr1_valid = 1'b0; bus.wr1_x = '0; bus.wr1_y = '0; bus.wr1_pixel = '0;
    bus.clr_start = 1'b0; bus.clr_color = '0;
  endtask

  task automatic do_reset;
    tick;
    idle;
    rst_n = 1'b0;
    tick;
    tick;
    rst_n = 1'b1;
    mdl_last = 1;
  endtask

  task automatic test_reset;
    idle;
    rst_n = 1'b0;
    repeat (3) tick;
    #1;
    n_checks++;
    if ({bus.rd_valid, bus.rd_pixel, bus.clr_busy, bus.clr_done, bus.wr_err} !== 16'h0000)
      $display("FAIL reset_outputs: got valid=%b pix=%h busy=%b done=%b err=%b want all 0",
               bus.rd_valid, bus.rd_pixel, bus.clr_busy, bus.clr_done, bus.wr_err);
    else n_pass++;
    n_checks++;
    if (bus.mem_en !== 1'b0) $display("FAIL reset_mem_en: got %b want 0", bus.mem_en);
    else n_pass++;
    tick;
    rst_n = 1'b1;
    mdl_last = 1;
  endtask

  task automatic test_read_path;
    mem[1283] = 12'hABC;
    tick; idle;
    bus.rd_req = 1'b1; bus.rd_x = 10'd3; bus.rd_y = 9'd2;
    #1;
    n_checks++;
    if ({bus.mem_en, bus.mem_we, bus.mem_addr} !== {1'b1, 1'b0, 19'd1283})
      $display("FAIL read_issue: got en=%b we=%b addr=%0d want en=1 we=0 addr=1283",
               bus.mem_en, bus.mem_we, bus.mem_addr);
    else n_pass++;
    tick; idle; #1;
    n_checks++;
    if (bus.rd_valid !== 1'b0) $display("FAIL read_lat1: got valid=%b want 0", bus.rd_valid);
    else n_pass++;
    tick; #1;
    n_checks++;
    if (bus.rd_valid !== 1'b1 || bus.rd_pixel !== 12'hABC)
      $display("FAIL read_lat2: got valid=%b pix=%h want valid=1 pix=abc", bus.rd_valid, bus.rd_pixel);
    else n_pass++;
    tick; #1;
    n_checks++;
    if (bus.rd_valid !== 1'b0) $display("FAIL read_lat3: got valid=%b want 0", bus.rd_valid);
    else n_pass++;
  endtask

  task automatic test_read_stream;
    rd_exp_t q[$];
    rd_exp_t e;
    rd_exp_t x;
    int rx, ry;
    q.push_back(13'h0);
    q.push_back(13'h0);
    for (int c = 0; c < 202; c++) begin
      tick; idle;
      e = 13'h0;
      if (c < 200) begin
        rx = $urandom_range(0, H - 1);
        ry = $urandom_range(0, V - 1);
        e.v = ($urandom % 4) != 0;
        e.p = mem[ry * H + rx];
        bus.rd_req = e.v; bus.rd_x = 10'(rx); bus.rd_y = 9'(ry);
      end
      q.push_back(e);
      x = q.pop_front();
      #1;
      n_checks++;
      if (bus.rd_valid !== x.v || (x.v && bus.rd_pixel !== x.p))
        $display("FAIL read_stream[%0d]: got valid=%b pix=%h want valid=%b pix=%h",
                 c, bus.rd_valid, bus.rd_pixel, x.v, x.p);
      else n_pass++;
    end
  endtask

  task automatic test_writer_contention;
    int px[2], py[2];
    logic [11:0] pp[2];
    int exp_g;
    for (int w = 0; w < 2; w++) begin
      px[w] = $urandom_range(0, H - 1); py[w] = $urandom_range(0, V - 1); pp[w] = 12'($urandom);
    end
    for (int i = 0; i < 9; i++) begin
      tick; idle;
      bus.wr0_valid = 1'b1; bus.wr0_x = 10'(px[0]); bus.wr0_y = 9'(py[0]); bus.wr0_pixel = pp[0];
      bus.wr1_valid = 1'b1; bus.wr1_x = 10'(px[1]); bus.wr1_y = 9'(py[1]); bus.wr1_pixel = pp[1];
      bus.rd_req = (i == 8); bus.rd_x = 10'd7; bus.rd_y = 9'd1;
      #1;
      exp_g = (i == 8) ? -1 : i % 2;
      n_checks++;
      if (bus.wr0_ready !== (exp_g == 0) || bus.wr1_ready !== (exp_g == 1))
        $display("FAIL contention_grant[%0d]: got rdy0=%b rdy1=%b want grant=%0d",
                 i, bus.wr0_ready, bus.wr1_ready, exp_g);
      else n_pass++;
      if (exp_g >= 0) begin
        n_checks++;
        if ({bus.mem_we, bus.mem_addr, bus.mem_wdata} !== {1'b1, 19'(py[exp_g] * H + px[exp_g]), pp[exp_g]})
          $display("FAIL contention_write[%0d]: got we=%b addr=%0d data=%h want we=1 addr=%0d data=%h",
                   i, bus.mem_we, bus.mem_addr, bus.mem_wdata, py[exp_g] * H + px[exp_g], pp[exp_g]);
        else n_pass++;
        mdl_last = exp_g;
        px[exp_g] = $urandom_range(0, H - 1); py[exp_g] = $urandom_range(0, V - 1);
        pp[exp_g] = 12'($urandom);
      end else begin
        n_checks++;
        if (bus.mem_we !== 1'b0) $display("FAIL contention_rd_block: got we=%b want 0", bus.mem_we);
        else n_pass++;
      end
    end
  endtask

  task automatic test_random_writes;
    bit pend[2];
    int px[2], py[2];
    logic [11:0] pp[2];
    int g, rx, ry, e_addr;
    logic rq, e_en, e_we;
    pend[0] = 1'b0; pend[1] = 1'b0;
    for (int c = 0; c < 300; c++) begin
      tick; idle;
      for (int w = 0; w < 2; w++) begin
        if (!pend[w]) begin
          pend[w] = ($urandom % 3) != 0;
          px[w] = $urandom_range(0, H - 1); py[w] = $urandom_range(0, V - 1); pp[w] = 12'($urandom);
        end
      end
      rq = ($urandom % 4) == 0;
      rx = $urandom_range(0, H - 1); ry = $urandom_range(0, V - 1);
      bus.rd_req = rq; bus.rd_x = 10'(rx); bus.rd_y = 9'(ry);
      bus.wr0_valid = pend[0]; bus.wr0_x = 10'(px[0]); bus.wr0_y = 9'(py[0]); bus.wr0_pixel = pp[0];
      bus.wr1_valid = pend[1]; bus.wr1_x = 10'(px[1]); bus.wr1_y = 9'(py[1]); bus.wr1_pixel = pp[1];
      #1;
      g = -1;
      if (!rq) begin
        if (pend[0] && pend[1]) g = 1 - mdl_last;
        else if (pend[0]) g = 0;
        else if (pend[1]) g = 1;
      end
      e_en = rq || (g >= 0);
      e_we = !rq && (g >= 0);
      e_addr = rq ? ry * H + rx : (g >= 0 ? py[g] * H + px[g] : 0);
      n_checks++;
      if (bus.wr0_ready !== (g == 0) || bus.wr1_ready !== (g == 1))
        $display("FAIL rand_grant[%0d]: got rdy0=%b rdy1=%b want grant=%0d", c, bus.wr0_ready, bus.wr1_ready, g);
      else n_pass++;
      n_checks++;
      if ({bus.mem_en, bus.mem_we} !== {e_en, e_we} || (e_en && bus.mem_addr !== 19'(e_addr)) ||
          (e_we && bus.mem_wdata !== pp[g]))
        $display("FAIL rand_mem[%0d]: got en=%b we=%b addr=%0d want en=%b we=%b addr=%0d",
                 c, bus.mem_en, bus.mem_we, bus.mem_addr, e_en, e_we, e_addr);
      else n_pass++;
      if (g >= 0) begin
        pend[g] = 1'b0;
        mdl_last = g;
      end
    end
  endtask

  task automatic test_clear(input bit preempt, input logic [11:0] color);
    int k, nw, last_w, done_k, bad_wr, bad_busy, bad_rdy, first_bad;
    int gx, gy;
    logic done_rq;
    gx = $urandom_range(0, H - 1); gy = $urandom_range(0, V - 1);
    tick; idle;
    bus.clr_start = 1'b1; bus.clr_color = color;
    bus.rd_req = preempt; bus.rd_x = 10'd1; bus.rd_y = 9'd0;
    #1;
    n_checks++;
    if (bus.clr_busy !== 1'b0) $display("FAIL clr_busy_start: got %b want 0", bus.clr_busy);
    else n_pass++;
    k = 0; nw = 0; last_w = -1; done_k = -1; bad_wr = 0; bad_busy = 0; bad_rdy = 0; first_bad = -1;
    done_rq = 1'b0;
    while (k < 3 * NPIX) begin
      tick; idle; k++;
      bus.clr_start = (k == 100); bus.clr_color = 12'hF00;
      bus.wr0_valid = 1'b1; bus.wr0_x = 10'(gx); bus.wr0_y = 9'(gy); bus.wr0_pixel = 12'h777;
      bus.rd_req = preempt && (k % 2 == 1);
      bus.rd_x = 10'($urandom_range(0, H - 1)); bus.rd_y = 9'($urandom_range(0, V - 1));
      #1;
      if (bus.clr_done === 1'b1) begin
        done_k = k;
        done_rq = bus.rd_req;
        break;
      end
      if (bus.clr_busy !== 1'b1) bad_busy++;
      if (bus.wr0_ready !== 1'b0 || bus.wr1_ready !== 1'b0) bad_rdy++;
      if (bus.rd_req) begin
        if (bus.mem_we !== 1'b0) bad_wr++;
      end else if ({bus.mem_en, bus.mem_we, bus.mem_addr, bus.mem_wdata} === {2'b11, 19'(nw), color}) begin
        nw++;
        last_w = k;
      end else begin
        bad_wr++;
        if (first_bad < 0) first_bad = k;
      end
    end
    n_checks++;
    if (done_k < 0) begin
      $display("FAIL clr_timeout: got no clr_done within %0d cycles want completion", 3 * NPIX);
      return;
    end
    n_pass++;
    n_checks++;
    if (nw !== NPIX || bad_wr !== 0)
      $display("FAIL clr_writes: got %0d in-order writes, %0d bad (first at cycle %0d) want %0d, 0 bad",
               nw, bad_wr, first_bad, NPIX);
    else n_pass++;
    n_checks++;
    if (bad_busy !== 0 || bad_rdy !== 0)
      $display("FAIL clr_busy_rdy: got %0d busy drops, %0d writer readies want 0, 0", bad_busy, bad_rdy);
    else n_pass++;
    n_checks++;
    if (done_k !== last_w + 1) $display("FAIL clr_done_lat: got done at %0d want %0d", done_k, last_w + 1);
    else n_pass++;
    n_checks++;
    if ((!preempt && last_w !== NPIX) || (preempt && (last_w < 2 * NPIX - 1 || last_w > 2 * NPIX + 1)))
      $display("FAIL clr_duration: got last write at cycle %0d want %0d", last_w, preempt ? 2 * NPIX : NPIX);
    else n_pass++;
    n_checks++;
    if (bus.clr_busy !== 1'b0 || bus.wr0_ready !== !done_rq)
      $display("FAIL clr_release: got busy=%b rdy0=%b want busy=0 rdy0=%b", bus.clr_busy, bus.wr0_ready, !done_rq);
    else n_pass++;
    if (!done_rq) mdl_last = 0;
    tick; idle; #1;
    n_checks++;
    if (bus.clr_done !== 1'b0) $display("FAIL clr_done_pulse: got %b want 0", bus.clr_done);
    else n_pass++;
  endtask

  task automatic test_reset_mid_clear;
    int nbad, ndone;
    tick; idle;
    bus.clr_start = 1'b1; bus.clr_color = 12'h5A5;
    nbad = 0;
    for (int k = 1; k <= 1000; k++) begin
      tick; idle; #1;
      if (bus.mem_we !== 1'b1 || bus.mem_addr !== 19'(k - 1)) nbad++;
    end
    n_checks++;
    if (nbad !== 0) $display("FAIL midclr_prefix: got %0d bad writes want 0", nbad);
    else n_pass++;
    tick; idle;
    bus.rd_req = 1'b1; bus.rd_x = 10'd1; bus.rd_y = 9'd1;
    tick; idle;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (bus.clr_busy !== 1'b0) $display("FAIL midclr_abort: got busy=%b want 0", bus.clr_busy);
    else n_pass++;
    tick; #1;
    n_checks++;
    if (bus.rd_valid !== 1'b0) $display("FAIL midread_drop: got valid=%b want 0", bus.rd_valid);
    else n_pass++;
    tick;
    rst_n = 1'b1;
    mdl_last = 1;
    ndone = 0;
    for (int k = 0; k < 6; k++) begin
      tick; #1;
      if (bus.clr_done !== 1'b0 || bus.clr_busy !== 1'b0) ndone++;
    end
    n_checks++;
    if (ndone !== 0) $display("FAIL midclr_no_done: got %0d cycles with done/busy want 0", ndone);
    else n_pass++;
    tick; idle;
    bus.clr_start = 1'b1; bus.clr_color = 12'h3C3;
    tick; idle; #1;
    n_checks++;
    if ({bus.mem_we, bus.mem_addr, bus.mem_wdata} !== {1'b1, 19'd0, 12'h3C3})
      $display("FAIL midclr_restart: got we=%b addr=%0d data=%h want we=1 addr=0 data=3c3",
               bus.mem_we, bus.mem_addr, bus.mem_wdata);
    else n_pass++;
    do_reset;
  endtask

  task automatic test_bounds;
    tick; idle;
    bus.wr0_valid = 1'b1; bus.wr0_x = 10'd640; bus.wr0_y = 9'd0; bus.wr0_pixel = 12'h123;
    #1;
    n_checks++;
    if (bus.wr0_ready !== 1'b1) $display("FAIL bounds_handshake: got rdy0=%b want 1", bus.wr0_ready);
    else n_pass++;
    n_checks++;
    if ((BOUNDS && {bus.mem_en, bus.mem_we} !== 2'b00) ||
        (!BOUNDS && {bus.mem_we, bus.mem_addr, bus.mem_wdata} !== {1'b1, 19'd640, 12'h123}))
      $display("FAIL bounds_write: got en=%b we=%b addr=%0d want we=%b addr=640",
               bus.mem_en, bus.mem_we, bus.mem_addr, !BOUNDS);
    else n_pass++;
    tick; idle;
    bus.wr1_valid = 1'b1; bus.wr1_x = 10'd5; bus.wr1_y = 9'd1; bus.wr1_pixel = 12'h456;
    #1;
    n_checks++;
    if (bus.wr_err !== BOUNDS) $display("FAIL bounds_err_set: got %b want %b", bus.wr_err, BOUNDS);
    else n_pass++;
    n_checks++;
    if ({bus.wr1_ready, bus.mem_we, bus.mem_addr} !== {2'b11, 19'd645})
      $display("FAIL bounds_inrange: got rdy1=%b we=%b addr=%0d want 1 1 645",
               bus.wr1_ready, bus.mem_we, bus.mem_addr);
    else n_pass++;
    repeat (3) begin
      tick; idle;
    end
    #1;
    n_checks++;
    if (bus.wr_err !== BOUNDS) $display("FAIL bounds_err_sticky: got %b want %b", bus.wr_err, BOUNDS);
    else n_pass++;
  endtask

  initial begin
    for (int i = 0; i < NPIX; i++) mem[i] = 12'($urandom);
    test_reset;
    test_read_path;
    test_read_stream;
    test_writer_contention;
    test_random_writes;
    test_clear(1'b0, 12'h00F);
    test_clear(1'b1, 12'hA5C);
    test_reset_mid_clear;
    test_bounds;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/frame_mem_arbiter.md
# frame_mem_arbiter

Arbitrates one single-port frame memory between the VGA scanout reader, two pixel writers (game logic and sprite engine) and an internal clear-screen sequencer. Scanout reads have absolute priority so the display never starves. The clear sequencer fills the frame with one colour. Writers share the remaining cycles round-robin. Sits between the game/render logic and the frame storage; the VGA timing generator drives the read port.

## Interface
- H_PIXELS, 640, frame width in pixels
- V_PIXELS, 480, frame height in pixels
- ADDR_W, $clog2(H_PIXELS*V_PIXELS) (19), memory address width
- clk  in  1  pixel-domain clock
- rst_n  in  1  reset; one clock; reset is asynchronous and active-low
- rd_req / rd_x / rd_y  in  1 / 10 / 9  scanout read request and coordinate
- rd_valid / rd_pixel  out  1 / 12  returned pixel {r,g,b} 4 bits each
- wr0_valid / wr0_x / wr0_y / wr0_pixel  in  1/10/9/12  writer 0 request
- wr0_ready  out  1  writer 0 accept
- wr1_valid / wr1_x / wr1_y / wr1_pixel / wr1_ready  as writer 0
- clr_start  in  1  pulse: start clear
- clr_color  in  12  fill colour, sampled on accepted clr_start
- clr_busy / clr_done  out  1 / 1  clear in progress / one-cycle completion pulse
- mem_en / mem_we / mem_addr / mem_wdata  out  1/1/ADDR_W/12  memory port
- mem_rdata  in  12  memory read data, valid one cycle after a mem_en & !mem_we cycle
- wr_err  out  1  sticky out-of-range write flag (see Configuration)

## Operation
- Address = y*H_PIXELS + x, computed in ADDR_W bits; no wrap.
- Per-cycle grant, priority: (1) rd_req, (2) clear sequencer while clr_busy, (3) writers.
- Read: rd_req drives mem_en=1, mem_we=0, mem_addr from rd_x/rd_y combinationally. It is never stalled.
- Clear FSM, states CLR_IDLE, CLR_RUN:
  - CLR_IDLE -> CLR_RUN on clr_start. Latch clr_color, clear counter to 0, assert clr_busy.
  - CLR_RUN issues write addr=counter, data=latched colour on every cycle without rd_req, then counter++.
  - When the write at H_PIXELS*V_PIXELS-1 issues: -> CLR_IDLE, clr_done pulses next cycle, clr_busy drops with it.
  - clr_start while busy is ignored. Counter does not advance on cycles preempted by rd_req.
- Writers:
  - wrN_ready = !rd_req & !clr_busy & (grant to N).
  - Transfer = valid & ready in the same cycle; the memory write issues that cycle.
  - Round-robin pointer last_grant updates on each transfer. When both are valid, grant goes to the writer not last granted.
  - A single valid writer is granted regardless of pointer.
- Writers hold x/y/pixel stable while valid & !ready.
- Outputs when no grant: mem_en=0, mem_we=0; mem_addr/mem_wdata don't-care (drive 0).

## Timing
- Read latency 2: rd_req at cycle t -> mem read at t -> mem_rdata at t+1 -> rd_pixel/rd_valid registered at t+2. Back-to-back reads are fully pipelined.
- Write: zero-latency issue on the handshake cycle.
- Clear of an unpreempted frame: H*V cycles from the cycle after clr_start to the last write. clr_done is one cycle after the last write.
- Reset values: rd_valid=0, rd_pixel=0, clr_busy=0, clr_done=0, wr_err=0, FSM=CLR_IDLE, counter=0, last_grant=writer 1 (writer 0 wins first tie).
- Reset mid-clear aborts immediately with no clr_done. Reset mid-read drops the in-flight pixel (rd_valid=0).
- Simultaneous rd_req and clr_start: read issues; FSM enters CLR_RUN; first clear write on the next free cycle.

## Configuration
- FB_ARB_BOUNDS_CHECK_EN defined:
  - A writer transfer with x>=H_PIXELS or y>=V_PIXELS is still handshaken (ready asserted per normal rules) but no memory write issues.
  - wr_err sets and stays set until reset.
- Undefined: no check; the address is used as computed; wr_err tied 0.

## Structure
- Shared package fb_pkg:
  - Pixel struct (r,g,b 4 bits each) and the 12-bit packed form.
  - H_PIXELS/V_PIXELS defaults, taken from the monitor parameters.
  - Clear FSM state enum.
- Sub-module fb_rr_arb2: 2-requester round-robin arbiter with enable and last_grant register.
- Address multiply is a constant-coefficient multiply, kept in the top.

## Test plan
- Read path: rd_req with (x=3,y=2); memory model holds 0xABC at addr 1283 -> rd_valid=1, rd_pixel=0xABC exactly 2 cycles later.
- Writer contention: wr0 and wr1 valid continuously, no rd_req -> grants alternate 0,1,0,1 starting with wr0; rd_req asserted for one cycle -> both ready=0 that cycle.
- Clear: clr_start, clr_color=0x00F, no reads -> 307200 writes of 0x00F to addrs 0..307199 in order; clr_done one cycle after the last write; writers ready=0 throughout.
- Preempted clear: rd_req every other cycle during clear -> total clear duration 614400 cycles ±1; no address skipped or duplicated.
- Reset mid-clear at counter=1000 -> clr_busy=0, no clr_done; a new clr_start restarts at addr 0.
- Bounds (FB_ARB_BOUNDS_CHECK_EN): wr0 write x=640,y=0 -> handshake completes, mem_we stays 0, wr_err=1 and sticky; without the macro -> write issues at addr 640.
